local_memory_arbiter: RTL

//  Shares one core-local SRAM port between two requesters: port A (core load/store unit) and port B (wishbone slave bridge).

---
 rtl/local_memory_arbiter_pkg.sv | 27 ++
 rtl/local_memory_arbiter_rr_pick2.sv | 23 ++
 rtl/local_memory_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/local_memory_arbiter_pkg.sv
// Shared encodings for local_memory_arbiter: FSM states, owner ids and the idle read-data fill.
// Optional grant statistics are enabled with LOCAL_MEMORY_ARBITER_STATS_EN.
package local_memory_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 24;
  localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
  localparam int unsigned DEFAULT_COUNTER_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'h0,
    ST_ACCESS = 2'h1,
    ST_FINISH = 2'h2
  } state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  // Read data presented on a port whenever it is not acknowledging a read.
  localparam logic RDATA_IDLE_BIT = 1'b1;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_A) ? OWNER_B : OWNER_A;
  endfunction

endpackage

// File: rtl/local_memory_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that did not own
// the previous completed transaction wins.
module local_memory_arbiter_rr_pick2
  import local_memory_arbiter_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_t last,
  output owner_t grant,
  output logic   valid
);

  always_comb begin
    grant = OWNER_A;
    valid = req_a | req_b;
    if (req_a && req_b) begin
      grant = other_owner(last);
    end else if (req_b) begin
      grant = OWNER_B;
    end
  end

endmodule

// File: rtl/local_memory_arbiter.sv
// Shares one core-local SRAM port between port A (LSU) and port B (wishbone bridge), one
// transaction in flight. Define LOCAL_MEMORY_ARBITER_STATS_EN for saturating grant counters.
module local_memory_arbiter
  import local_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
`endif
  localparam int unsigned SEL_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,

  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [SEL_WIDTH-1:0]     a_sel,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_ack,
  output logic [DATA_WIDTH-1:0]    a_rdata,

  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [SEL_WIDTH-1:0]     b_sel,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_ack,
  output logic [DATA_WIDTH-1:0]    b_rdata,

  output logic                     mem_enable,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [SEL_WIDTH-1:0]     mem_byte_select,
  output logic [DATA_WIDTH-1:0]    mem_data_write,
  input  logic [DATA_WIDTH-1:0]    mem_data_read,
  input  logic                     mem_busy
`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
  ,
  output logic [COUNTER_WIDTH-1:0] grant_count_a,
  output logic [COUNTER_WIDTH-1:0] grant_count_b
`endif
);

  localparam logic [DATA_WIDTH-1:0] RDATA_IDLE = {DATA_WIDTH{RDATA_IDLE_BIT}};

  state_t                   state;
  owner_t                   owner;
  owner_t                   last_owner;
  owner_t                   pick_grant;
  logic                     pick_valid;

  logic                     owner_req;
  logic                     owner_we;
  logic [ADDRESS_WIDTH-1:0] owner_addr;
  logic [SEL_WIDTH-1:0]     owner_sel;
  logic [DATA_WIDTH-1:0]    owner_wdata;

  // Current owner's request fields; only meaningful while in ACCESS.
  assign owner_req   = (owner == OWNER_A) ? a_req   : b_req;
  assign owner_we    = (owner == OWNER_A) ? a_we    : b_we;
  assign owner_addr  = (owner == OWNER_A) ? a_addr  : b_addr;
  assign owner_sel   = (owner == OWNER_A) ? a_sel   : b_sel;
  assign owner_wdata = (owner == OWNER_A) ? a_wdata : b_wdata;

  local_memory_arbiter_rr_pick2 u_pick (
    .req_a (a_req),
    .req_b (b_req),
    .last  (last_owner),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // SRAM side follows the owner directly so an access starts the cycle after the grant.
  always_comb begin
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_byte_select  = '0;
    mem_data_write   = '0;
    if ((state == ST_ACCESS) && owner_req) begin
      mem_enable       = 1'b1;
      mem_write_enable = owner_we;
      mem_address      = owner_addr;
      mem_byte_select  = owner_sel;
      if (owner_we) begin
        mem_data_write = owner_wdata;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= ST_IDLE;
      owner      <= OWNER_A;
      last_owner <= OWNER_B;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= RDATA_IDLE;
      b_rdata    <= RDATA_IDLE;
    end else begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= RDATA_IDLE;
      b_rdata <= RDATA_IDLE;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner <= pick_grant;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A dropped request abandons the access without an ack or fairness update.
          if (!owner_req) begin
            state <= ST_IDLE;
          end else if (!mem_busy) begin
            state      <= ST_FINISH;
            last_owner <= owner;
            if (owner == OWNER_A) begin
              a_ack   <= 1'b1;
              a_rdata <= owner_we ? RDATA_IDLE : mem_data_read;
            end else begin
              b_ack   <= 1'b1;
              b_rdata <= owner_we ? RDATA_IDLE : mem_data_read;
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOCAL_MEMORY_ARBITER_STATS_EN
  // Saturating per-port completion counters.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      grant_count_a <= '0;
      grant_count_b <= '0;
    end else begin
      if (a_ack && (grant_count_a != '1)) begin
        grant_count_a <= grant_count_a + COUNTER_WIDTH'(1);
      end
      if (b_ack && (grant_count_b != '1)) begin
        grant_count_b <= grant_count_b + COUNTER_WIDTH'(1);
      end
    end
  end
`endif

endmodule
